bloco_operativo: RTL and testbench
==================================

// Module: bloco_operativo
// PURPOSE
//  Datapath slaved to the FSM control block: holds registers X, H, S and one ALU.
//  Operand and write-source selects come from control outputs m0/m1/m2/h/Reg_*.
//  Result S is captured on control 'valid' into a 1-entry output buffer.
//  The buffer drains downstream with a valid/ready handshake; buf_full back-pressures control.
// PARAMETERS
//  WIDTH   16  datapath width (X, H, S, constants, result)
//  C0      1   constant selected by m0==3
//  C1      0   constant selected by m1==3
// PORTS
//  clock      in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  x_in       in   WIDTH  operand loaded into X
//  ld_x       in   1      load X <= x_in (control Reg_X)
//  ld_h       in   1      load H <= write source (control Reg_H)
//  ld_s       in   1      load S <= write source (control Reg_S)
//  h          in   1      ALU op: 0 = A+B, 1 = A*B
//  m0         in   2      ALU A select: 0 X, 1 H, 2 S, 3 C0
//  m1         in   2      ALU B select: 0 X, 1 H, 2 S, 3 C1
//  m2         in   2      write source: 0 ALU, 1 x_in, 2 ALU>>1 (logical), 3 zero
//  capture    in   1      control 'valid': push S into output buffer
//  res_data   out  WIDTH  buffered result
//  res_valid  out  1      buffer holds data
//  res_ready  in   1      downstream accepts res_data
//  buf_full   out  1      = res_valid and not res_ready; control holds while high
//  ovf        out  1      sticky: an ALU result exceeded WIDTH bits and was written
//  overrun    out  1      sticky: capture while buf_full, sample dropped
// BEHAVIOUR
//  - Reset: X=H=S=0, res_data=0, res_valid=0, ovf=0, overrun=0. Reset overrides everything.
//  - ALU is combinational on the current X/H/S (pre-edge values).
//    The full result is WIDTH+1 bits for add and 2*WIDTH bits for mul, then truncated to WIDTH.
//  - Registers load on the edge after their ld_* is sampled: 1-cycle latency.
//  - ld_h and ld_s together: both take the same write source.
//  - ld_x together with m0/m1 selecting X: the ALU uses the old X.
//  - ovf sets on any ld_h/ld_s edge with m2 in {0,2} where the truncated bits are nonzero.
//  - Output buffer, one entry:
//    - capture & !res_valid: res_data <= S (pre-edge), res_valid <= 1.
//    - res_valid & res_ready & !capture: res_valid <= 0.
//    - capture & res_valid & res_ready: pop and push in the same edge; res_data <= S, valid stays 1.
//    - capture & res_valid & !res_ready: data kept, overrun <= 1.
//  - ld_s & capture in the same cycle: the buffer gets the OLD S.
//  - res_data is stable while res_valid & !res_ready.
//  - ovf and overrun clear only on reset.
// CONFIGURATION
//  SAT_EN defined: on ALU overflow the written value is {WIDTH{1'b1}} instead of the truncated value.
//    Applies to m2=2 before the shift; ovf still sets.
//  SAT_EN undefined: wrap-around (truncate). Nothing else changes.
// STRUCTURE
//  - bloco_pkg: localparams for the m0/m1 codes (SEL_X, SEL_H, SEL_S, SEL_K),
//    the m2 codes (WR_ALU, WR_IN, WR_SHR, WR_ZERO) and the ALU ops (OP_ADD, OP_MUL).
//  - Sub-module alu_unit: combinational.
//    - Inputs: a, b, op.
//    - Outputs: WIDTH result and an overflow flag.
//    - Saturation lives here under SAT_EN.
//  - The register file, muxes and output buffer stay in bloco_operativo.
// TESTING (WIDTH=16, C0=1, C1=0)
//  1. Reset mid-sequence after X=5, H=7 -> next cycle all registers 0, res_valid=0, ovf=0.
//  2. x_in=3, ld_x; then m0=0, m1=0, h=1, m2=0, ld_h; then m0=1, m1=3, h=0, ld_s; then capture
//     -> S=9, res_data=9, res_valid=1.
//  3. X=16'h8000, h=1, m0=m1=0, ld_s -> ovf=1; S=0 without SAT_EN, S=16'hFFFF with SAT_EN.
//  4. res_ready=0, capture S=4, then capture S=6 -> res_data stays 4, overrun=1, buf_full=1.
//  5. res_valid with data 4, res_ready=1, capture S=6 in the same cycle -> res_data=6, res_valid=1, overrun=0.
//  6. S=10, ld_s with m2=3 and capture in the same cycle -> res_data=10, S=0 after the edge.

Source files
------------

// File: rtl/bloco_pkg.sv
// bloco_pkg: select, write-source and ALU op codes shared by the operative block.
package bloco_pkg;
  localparam logic [1:0] SEL_X = 2'd0;
  localparam logic [1:0] SEL_H = 2'd1;
  localparam logic [1:0] SEL_S = 2'd2;
  localparam logic [1:0] SEL_K = 2'd3;
  localparam logic [1:0] WR_ALU = 2'd0;
  localparam logic [1:0] WR_IN = 2'd1;
  localparam logic [1:0] WR_SHR = 2'd2;
  localparam logic [1:0] WR_ZERO = 2'd3;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;
endpackage

// File: rtl/alu_unit.sv
// alu_unit: combinational add/multiply with overflow flag.
// SAT_EN defined: an overflowing result saturates to all ones instead of wrapping.
module alu_unit
  import bloco_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] trunc;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    trunc = (op == OP_MUL) ? prod[WIDTH-1:0] : sum[WIDTH-1:0];
    ovf = (op == OP_MUL) ? |prod[2*WIDTH-1:WIDTH] : sum[WIDTH];
`ifdef SAT_EN
    y = ovf ? {WIDTH{1'b1}} : trunc;
`else
    y = trunc;
`endif
  end
endmodule

// File: rtl/bloco_operativo.sv
// bloco_operativo: X/H/S datapath with one ALU and a 1-entry handshaked result buffer.
// SAT_EN (in alu_unit) selects saturating instead of wrapping ALU results.
module bloco_operativo
  import bloco_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int C0 = 1,
  parameter int C1 = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             ld_x,
  input  logic             ld_h,
  input  logic             ld_s,
  input  logic             h,
  input  logic [1:0]       m0,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  input  logic             capture,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             buf_full,
  output logic             ovf,
  output logic             overrun
);
  localparam logic [WIDTH-1:0] K0 = WIDTH'(C0);
  localparam logic [WIDTH-1:0] K1 = WIDTH'(C1);
  logic [WIDTH-1:0] x_q, x_d, h_q, h_d, s_q, s_d, res_data_q, res_data_d;
  logic [WIDTH-1:0] op_a, op_b, alu_y, wr_src;
  logic res_valid_q, res_valid_d, ovf_q, ovf_d, overrun_q, overrun_d;
  logic alu_ovf, push;
  alu_unit #(.WIDTH(WIDTH)) u_alu (
    .a  (op_a),
    .b  (op_b),
    .op (h),
    .y  (alu_y),
    .ovf(alu_ovf)
  );
  always_comb begin
    op_a = (m0 == SEL_X) ? x_q : (m0 == SEL_H) ? h_q : (m0 == SEL_S) ? s_q : K0;
    op_b = (m1 == SEL_X) ? x_q : (m1 == SEL_H) ? h_q : (m1 == SEL_S) ? s_q : K1;
    wr_src = (m2 == WR_ALU) ? alu_y : (m2 == WR_IN) ? x_in :
             (m2 == WR_SHR) ? (alu_y >> 1) : '0;
    x_d = ld_x ? x_in : x_q;
    h_d = ld_h ? wr_src : h_q;
    s_d = ld_s ? wr_src : s_q;
    ovf_d = ovf_q | ((ld_h | ld_s) & (m2 == WR_ALU | m2 == WR_SHR) & alu_ovf);
    // a capture is accepted when the slot is empty or being drained this same edge
    push = capture & (~res_valid_q | res_ready);
    res_data_d = push ? s_q : res_data_q;
    res_valid_d = push | (res_valid_q & ~res_ready);
    overrun_d = overrun_q | (capture & res_valid_q & ~res_ready);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      h_q <= '0;
      s_q <= '0;
      res_data_q <= '0;
      res_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      x_q <= x_d;
      h_q <= h_d;
      s_q <= s_d;
      res_data_q <= res_data_d;
      res_valid_q <= res_valid_d;
      ovf_q <= ovf_d;
      overrun_q <= overrun_d;
    end
  end
  assign res_data = res_data_q;
  assign res_valid = res_valid_q;
  assign buf_full = res_valid_q & ~res_ready;
  assign ovf = ovf_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_bloco_operativo.sv
// tb_bloco_operativo: directed scenarios plus random traffic against an arithmetic reference model.
module tb_bloco_operativo;
  logic clock = 1'b0;
  logic reset;
  logic [15:0] x_in;
  logic ld_x, ld_h, ld_s, h, capture, res_ready;
  logic [1:0] m0, m1, m2;
  logic [15:0] res_data;
  logic res_valid, buf_full, ovf, overrun;
  int checks = 0;
  int failures = 0;
  logic [15:0] mx, mh, ms;
  bit mocc, movf, movr;
  logic [15:0] sb[$];

  bloco_operativo #(.WIDTH(16), .C0(1), .C1(0)) dut (
    .clock(clock), .reset(reset), .x_in(x_in), .ld_x(ld_x), .ld_h(ld_h), .ld_s(ld_s),
    .h(h), .m0(m0), .m1(m1), .m2(m2), .capture(capture), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .buf_full(buf_full), .ovf(ovf),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned pick(input logic [1:0] s, input longint unsigned k);
    return (s == 2'd0) ? mx : (s == 2'd1) ? mh : (s == 2'd2) ? ms : k;
  endfunction

  // reference model: advances on every rising edge using the inputs the DUT samples
  always @(posedge clock) begin
    longint unsigned a, b, full, v, src;
    bit of;
    if (reset) begin
      mx = 0; mh = 0; ms = 0; mocc = 0; movf = 0; movr = 0;
      sb.delete();
    end else begin
      a = pick(m0, 1);
      b = pick(m1, 0);
      full = h ? a * b : a + b;
      of = full > 64'hFFFF;
`ifdef SAT_EN
      v = of ? 64'hFFFF : (full & 64'hFFFF);
`else
      v = full & 64'hFFFF;
`endif
      src = (m2 == 2'd0) ? v : (m2 == 2'd1) ? longint'(x_in) : (m2 == 2'd2) ? (v >> 1) : 0;
      if (mocc && res_ready) mocc = 0;
      if (capture) begin
        if (!mocc) begin
          sb.push_back(ms);
          mocc = 1;
        end else movr = 1;
      end
      if ((ld_h || ld_s) && (m2 == 2'd0 || m2 == 2'd2) && of) movf = 1;
      if (ld_x) mx = x_in;
      if (ld_h) mh = src[15:0];
      if (ld_s) ms = src[15:0];
    end
  end

  // monitor: compares status every cycle and drains the scoreboard on handshakes
  always @(negedge clock) begin
    chk("res_valid", res_valid, mocc);
    chk("buf_full", buf_full, mocc && !res_ready);
    chk("ovf", ovf, movf);
    chk("overrun", overrun, movr);
    if (res_valid) begin
      if (sb.size() == 0) chk("sb_nonempty", 0, 1);
      else begin
        chk("res_data", res_data, sb[0]);
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic put(input logic [15:0] xi = 0, input bit lx = 0, input bit lh = 0,
                     input bit ls = 0, input bit hh = 0, input logic [1:0] a0 = 0,
                     input logic [1:0] a1 = 0, input logic [1:0] a2 = 0,
                     input bit cap = 0, input bit rdy = 1, input bit rst = 0);
    x_in = xi; ld_x = lx; ld_h = lh; ld_s = ls; h = hh;
    m0 = a0; m1 = a1; m2 = a2; capture = cap; res_ready = rdy; reset = rst;
    @(posedge clock);
    #1;
  endtask

  initial begin
    put(.rst(1));
    put(.rst(1));
    // scenario 1: reset after loading X and H
    put(.xi(5), .lx(1));
    put(.xi(7), .lh(1), .a2(1));
    put(.rst(1));
    chk("t1_valid", res_valid, 0);
    chk("t1_ovf", ovf, 0);
    put(.cap(1), .rdy(0));
    chk("t1_s_zero", res_data, 0);
    put();
    // scenario 2: X=3, H=X*X, S=H+C1, capture
    put(.xi(3), .lx(1));
    put(.hh(1), .a0(0), .a1(0), .a2(0), .lh(1));
    put(.a0(1), .a1(3), .hh(0), .a2(0), .ls(1));
    put(.cap(1), .rdy(0));
    chk("t2_data", res_data, 9);
    chk("t2_valid", res_valid, 1);
    put();
    // scenario 3: 0x8000 squared overflows
    put(.xi(16'h8000), .lx(1));
    put(.hh(1), .ls(1));
    chk("t3_ovf", ovf, 1);
    put(.cap(1), .rdy(0));
`ifdef SAT_EN
    chk("t3_s", res_data, 16'hFFFF);
`else
    chk("t3_s", res_data, 0);
`endif
    put();
    // scenario 4: second capture while stalled is dropped
    put(.rst(1));
    put(.xi(4), .a2(1), .ls(1));
    put(.cap(1), .rdy(0));
    put(.xi(6), .a2(1), .ls(1), .rdy(0));
    put(.cap(1), .rdy(0));
    chk("t4_data", res_data, 4);
    chk("t4_overrun", overrun, 1);
    chk("t4_full", buf_full, 1);
    // scenario 5: pop and push on the same edge
    put(.rst(1));
    put(.xi(4), .a2(1), .ls(1));
    put(.cap(1), .rdy(0));
    put(.xi(6), .a2(1), .ls(1), .rdy(0));
    put(.cap(1), .rdy(1));
    chk("t5_data", res_data, 6);
    chk("t5_valid", res_valid, 1);
    chk("t5_overrun", overrun, 0);
    put();
    // scenario 6: capture sees S before the same-edge clear
    put(.xi(10), .a2(1), .ls(1));
    put(.ls(1), .a2(3), .cap(1), .rdy(0));
    chk("t6_data", res_data, 10);
    put(.cap(1), .rdy(1));
    chk("t6_s_cleared", res_data, 0);
    put();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      put(.xi(($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(300))),
          .lx($urandom_range(1)), .lh($urandom_range(1)), .ls($urandom_range(1)),
          .hh($urandom_range(1)), .a0(2'($urandom)), .a1(2'($urandom)), .a2(2'($urandom)),
          .cap($urandom_range(2) == 0), .rdy($urandom_range(3) != 0),
          .rst($urandom_range(199) == 0));
    end
    repeat (3) put();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
